// File: rtl/fsm_stream_sched.sv
// Round-robin scheduler sharing one serial 3-state detector between N requesters.
// Each grant clears the detector, shifts the word in MSB first, and counts cycles with detector output high.
module fsm_stream_sched #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   data,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     done,
   output logic [CNT_W-1:0] result,
   output logic             busy,
   output logic             fsm_in,
   output logic             fsm_rst_n,
   input  logic             fsm_out
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_DRAIN,
      S_REPORT
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] acc_q, acc_d;

   logic [W-1:0]     word_arr [N];
   logic             arb_found;
   logic [PW-1:0]    arb_idx;
   logic [N-1:0]     arb_onehot;
   logic             sample_en;
   int               cand;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         assign word_arr[gi]   = data[gi*W +: W];
         assign arb_onehot[gi] = arb_found && (arb_idx == PW'(gi));
         assign done[gi]       = (state_q == S_REPORT) && gnt_q[gi];
      end
   endgenerate

   // Search upward from the lane after the last winner, wrapping modulo N.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(ptr_q) + k) % N;
         if (!arb_found && req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = PW'(cand);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      shreg_d   = shreg_q;
      ptr_d     = ptr_q;
      bit_cnt_d = bit_cnt_q;
      acc_d     = acc_q;
      sample_en = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               gnt_d     = arb_onehot;
               shreg_d   = word_arr[arb_idx];
               ptr_d     = arb_idx;
               acc_d     = '0;
               bit_cnt_d = '0;
               state_d   = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            // The first SHIFT cycle still shows the cleared state, so it is not counted.
            sample_en = (bit_cnt_q != '0);
            if (bit_cnt_q == BW'(W - 1)) begin
               bit_cnt_d = '0;
               state_d   = S_DRAIN;
            end else begin
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         S_DRAIN: begin
            sample_en = 1'b1;
            state_d   = S_REPORT;
         end
         S_REPORT: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      if (sample_en && fsm_out && (acc_q != {CNT_W{1'b1}})) begin
         acc_d = acc_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         shreg_q   <= '0;
         ptr_q     <= PW'(N - 1);
         bit_cnt_q <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         shreg_q   <= shreg_d;
         ptr_q     <= ptr_d;
         bit_cnt_q <= bit_cnt_d;
         acc_q     <= acc_d;
      end
   end

   // Detector drive depends on state registers only; RST gating holds the detector cleared during reset.
   assign fsm_in    = (state_q == S_SHIFT) && shreg_q[W-1];
   assign fsm_rst_n = RST && (state_q != S_CLEAR);
   assign busy      = (state_q != S_IDLE);
   assign gnt       = gnt_q;
   assign result    = (state_q == S_REPORT) ? acc_q : '0;

endmodule

// File: tb/tb_fsm_stream_sched.sv
// Directed and random streams against fsm_stream_sched with a behavioural A/B/C detector attached.
module tb_fsm_stream_sched;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic [N-1:0]     req;
   logic [N*W-1:0]   data;
   logic [N-1:0]     gnt;
   logic [N-1:0]     done;
   logic [CNT_W-1:0] result;
   logic             busy;
   logic             fsm_in;
   logic             fsm_rst_n;
   logic             fsm_out;

   int vectors     = 0;
   int miscompares = 0;
   int last_wait   = 0;

   fsm_stream_sched #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .req      (req),
      .data     (data),
      .gnt      (gnt),
      .done     (done),
      .result   (result),
      .busy     (busy),
      .fsm_in   (fsm_in),
      .fsm_rst_n(fsm_rst_n),
      .fsm_out  (fsm_out)
   );

   always #5 CLK = ~CLK;

   // Detector: A=0, B=1, C=2; output high in C; synchronous active-low reset.
   logic [1:0] det_q = 2'd0;
   always @(posedge CLK) begin
      if (!fsm_rst_n) det_q <= 2'd0;
      else begin
         case (det_q)
            2'd0:    det_q <= fsm_in ? 2'd1 : 2'd0;
            2'd1:    det_q <= fsm_in ? 2'd1 : 2'd2;
            default: det_q <= fsm_in ? 2'd0 : 2'd2;
         endcase
      end
   end
   assign fsm_out = (det_q == 2'd2);

   function automatic int ref_count(input logic [W-1:0] w);
      int s;
      int c;
      s = 0;
      c = 0;
      for (int i = W - 1; i >= 0; i--) begin
         case (s)
            0:       s = w[i] ? 1 : 0;
            1:       s = w[i] ? 1 : 2;
            default: s = w[i] ? 0 : 2;
         endcase
         if (s == 2) c++;
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for a grant, then checks every cycle of the stream up to the following IDLE cycle.
   task automatic observe(input int exp_idx, input logic [W-1:0] exp_word, input int exp_res,
                          input int drop_at);
      logic [N-1:0] oh;
      logic [W-1:0] pat;
      bit           ctrl_ok;
      bit           got;
      oh  = N'(1) << exp_idx;
      got = 1'b0;
      last_wait = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         last_wait++;
         if (gnt !== '0) got = 1'b1;
      end
      check("grant_seen", 32'(got), 32'd1);
      if (!got) return;
      check("clear_gnt", 32'(gnt), 32'(oh));
      check("clear_rst_n", 32'(fsm_rst_n), 32'd0);
      check("clear_busy", 32'(busy), 32'd1);
      pat     = '0;
      ctrl_ok = 1'b1;
      for (int i = 0; i < W; i++) begin
         @(negedge CLK);
         pat[W-1-i] = fsm_in;
         if (fsm_rst_n !== 1'b1 || gnt !== oh || done !== '0) ctrl_ok = 1'b0;
         if (i == drop_at) begin
            req[exp_idx]          = 1'b0;
            data[exp_idx*W +: W]  = ~exp_word;
         end
      end
      check("shift_pattern", 32'(pat), 32'(exp_word));
      check("shift_ctrl", 32'(ctrl_ok), 32'd1);
      @(negedge CLK);
      check("drain_done", 32'(done), 32'd0);
      check("drain_gnt", 32'(gnt), 32'(oh));
      @(negedge CLK);
      check("report_done", 32'(done), 32'(oh));
      check("report_result", 32'(result), 32'(exp_res));
      check("report_gnt", 32'(gnt), 32'(oh));
      @(negedge CLK);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_result", 32'(result), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] w;
      int           idx;
      bit           got;

      RST  = 1'b0;
      req  = '0;
      data = '0;
      repeat (3) @(negedge CLK);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fsm_in", 32'(fsm_in), 32'd0);
      check("rst_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      check("idle_rst_n", 32'(fsm_rst_n), 32'd1);
      check("idle_no_req", 32'(busy), 32'd0);

      // First stream after reset: requester 0 wins, 0x80 -> B,C,C,C,C,C,C,C -> 7.
      data[0*W +: W] = 8'h80;
      req = 4'b0001;
      observe(0, 8'h80, 7, -1);
      check("first_wait", 32'(last_wait), 32'd1);
      req = '0;

      // Single requesters: 0xAA -> 2, 0xFF -> 0, 0x00 -> 0.
      data[1*W +: W] = 8'hAA;
      req = 4'b0010;
      observe(1, 8'hAA, 2, -1);
      req = '0;
      data[2*W +: W] = 8'hFF;
      req = 4'b0100;
      observe(2, 8'hFF, 0, -1);
      req = '0;
      data[3*W +: W] = 8'h00;
      req = 4'b1000;
      observe(3, 8'h00, 0, -1);
      req = '0;
      @(negedge CLK);
      check("stay_idle", 32'(busy), 32'd0);

      // All four requesting: round-robin 0,1,2,3,0 with one IDLE cycle between grants.
      data = {8'h40, 8'hFF, 8'hAA, 8'h80};
      req  = 4'b1111;
      observe(0, 8'h80, 7, -1);
      observe(1, 8'hAA, 2, -1);
      check("rr_gap1", 32'(last_wait), 32'd1);
      observe(2, 8'hFF, 0, -1);
      check("rr_gap2", 32'(last_wait), 32'd1);
      observe(3, 8'h40, 6, -1);
      check("rr_gap3", 32'(last_wait), 32'd1);
      observe(0, 8'h80, 7, -1);
      check("rr_gap4", 32'(last_wait), 32'd1);
      req = '0;

      // Owner 2 drops req and its data changes in SHIFT cycle 3; latched 0x40 -> 6.
      data[2*W +: W] = 8'h40;
      req = 4'b0100;
      observe(2, 8'h40, 6, 3);
      check("drop_req_cleared", 32'(req), 32'd0);

      // Reset during SHIFT cycle 4, then regrant of requester 1.
      data[1*W +: W] = 8'h80;
      req = 4'b0010;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         if (gnt !== '0) got = 1'b1;
      end
      check("abort_grant_seen", 32'(got), 32'd1);
      repeat (5) @(negedge CLK);
      check("abort_in_shift", 32'(gnt), 32'b0010);
      RST = 1'b0;
      #1;
      check("abort_gnt", 32'(gnt), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_fsm_in", 32'(fsm_in), 32'd0);
      check("abort_rst_n", 32'(fsm_rst_n), 32'd0);
      @(posedge CLK);
      #1;
      check("abort_hold_done", 32'(done), 32'd0);
      check("abort_hold_gnt", 32'(gnt), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      observe(1, 8'h80, 7, -1);
      req = '0;

      // Random single-requester streams checked against the reference detector count.
      for (int s = 0; s < 1000; s++) begin
         idx  = int'($urandom_range(0, N - 1));
         data = {$urandom};
         w    = W'($urandom);
         data[idx*W +: W] = w;
         req  = N'(1) << idx;
         observe(idx, w, ref_count(w), -1);
         req  = '0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
